// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank multi-channel clock generator.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A channel config is usable only if the high pulse and phase both fit strictly inside the period.
  function automatic logic cfg_valid_chk(input logic [31:0] ch, input logic [31:0] div,
                                         input logic [31:0] high, input logic [31:0] phase,
                                         input logic [31:0] n_ch);
    logic ok;
    ok = 1'b1;
    if (ch >= n_ch)        ok = 1'b0;
    else if (div < 32'd2)  ok = 1'b0;
    else if (high == 32'd0) ok = 1'b0;
    else if (high >= div)  ok = 1'b0;
    else if (phase >= div) ok = 1'b0;
    else                   ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided output: shadow config, free-running phase counter and registered outclk/tick.
module clk_div_channel #(
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic             live,
  input  logic             wr,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] high,
  input  logic [DIV_W-1:0] phase,
  output logic             outclk,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_r, high_r, phase_r, cnt_r, cnt_next_s;
  logic             en_r, en_next_s, outclk_r, tick_r, outclk_next_s;

  // Next counter/enable/output; reload places the rising edge phase cycles after alignment.
  always_comb begin
    cnt_next_s = ZERO;
    if (align) begin
      if (phase_r == ZERO) cnt_next_s = ZERO;
      else                 cnt_next_s = div_r - phase_r;
    end else if (cnt_r == div_r - ONE) begin
      cnt_next_s = ZERO;
    end else begin
      cnt_next_s = cnt_r + ONE;
    end
    en_next_s     = live && (en_r || (cnt_next_s == ZERO));
    outclk_next_s = en_next_s && (cnt_next_s < high_r);
  end

  // Shadow registers, counter and output flops.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div_r    <= DIV_W'(DEF_DIV);
      high_r   <= DIV_W'(DEF_HIGH);
      phase_r  <= ZERO;
      cnt_r    <= ZERO;
      en_r     <= 1'b0;
      outclk_r <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      if (wr) begin
        div_r   <= div;
        high_r  <= high;
        phase_r <= phase;
      end
      cnt_r    <= cnt_next_s;
      en_r     <= en_next_s;
      outclk_r <= outclk_next_s;
      tick_r   <= outclk_next_s && !outclk_r;
    end
  end

  assign outclk = outclk_r;
  assign tick   = tick_r;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel phase-aligned clock divider: align/settle/lock sequencer, config handshake and channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  parameter int DEF_HIGH    = 1,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [N_CH-1:0]  outclk,
  output logic [N_CH-1:0]  tick,
  output logic             locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_e            state_r, state_next_s;
  logic [LOCK_W-1:0] lock_cnt_r;
  logic              locked_r, cfg_ready_r, cfg_err_r;
  logic              accept_s, cfg_ok_s, take_s, align_s, live_s;
  logic [N_CH-1:0]   wr_s;

  // Handshake decode and next-state; any accepted config forces a full realign.
  always_comb begin
    accept_s = cfg_valid && cfg_ready_r;
    cfg_ok_s = cfg_valid_chk(32'(cfg_ch), 32'(cfg_div), 32'(cfg_high), 32'(cfg_phase), 32'(N_CH));
    take_s   = accept_s && cfg_ok_s;
    state_next_s = state_r;
    case (state_r)
      ALIGN:  state_next_s = SETTLE;
      SETTLE: begin
        if (take_s)                                      state_next_s = ALIGN;
        else if (lock_cnt_r == LOCK_W'(LOCK_CYCLES - 1)) state_next_s = LOCKED;
        else                                             state_next_s = SETTLE;
      end
      LOCKED: begin
        if (take_s) state_next_s = ALIGN;
        else        state_next_s = LOCKED;
      end
      default: state_next_s = ALIGN;
    endcase
    align_s = (state_r == ALIGN);
    live_s  = (state_next_s == LOCKED);
    for (int i = 0; i < N_CH; i++) begin
      wr_s[i] = take_s && (cfg_ch == CH_W'(i));
    end
  end

  // Sequencer state, settle counter and registered status outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= ALIGN;
      lock_cnt_r  <= LOCK_W'(0);
      locked_r    <= 1'b0;
      cfg_ready_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ALIGN)       lock_cnt_r <= LOCK_W'(0);
      else if (state_r == SETTLE) lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
      else                        lock_cnt_r <= lock_cnt_r;
      locked_r    <= (state_next_s == LOCKED);
      cfg_ready_r <= (state_next_s != ALIGN);
      cfg_err_r   <= accept_s && !cfg_ok_s;
    end
  end

  assign locked    = locked_r;
  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_ch (
      .refclk(refclk),
      .rst   (rst),
      .align (align_s),
      .live  (live_s),
      .wr    (wr_s[g]),
      .div   (cfg_div),
      .high  (cfg_high),
      .phase (cfg_phase),
      .outclk(outclk[g]),
      .tick  (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a cycle-indexed arithmetic model predicts every output each cycle.
module tb_clk_div_bank;

  localparam int N_CH = 3;
  localparam int DIV_W = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W = 2;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_high = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic             cfg_err;
  logic [N_CH-1:0]  outclk, tick;
  logic             locked;

  clk_div_bank #(
    .N_CH(N_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DEF_DIV(2), .DEF_HIGH(1)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int              cyc;
    logic            lk;
    logic            rdy;
    logic            err;
    logic [N_CH-1:0] oc;
    logic [N_CH-1:0] tk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: n = edges since reset release, align_at = cycle spent in ALIGN
  int   n = 0;
  int   align_at = 0;
  int   m_div[N_CH];
  int   m_high[N_CH];
  int   m_phase[N_CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want,
                       input int cyc);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  function automatic bit req_ok(input int ch, input int d, input int h, input int p);
    return (ch < N_CH) && (d >= 2) && (h >= 1) && (h < d) && (p < d);
  endfunction

  function automatic int pos(input int t, input int a, input int p, input int d);
    return (((t - a - p) % d) + d) % d;
  endfunction

  task automatic model_reset();
    n = 0;
    align_at = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_div[i] = 2; m_high[i] = 1; m_phase[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    bit   acc, ok;
    int   a, lock_at, r, first, c;
    n = n + 1;
    acc = cfg_valid && ((n - 1) != align_at);
    ok  = req_ok(int'(cfg_ch), int'(cfg_div), int'(cfg_high), int'(cfg_phase));
    e.cyc = n;
    e.err = acc && !ok;
    if (acc && ok) begin
      m_div[cfg_ch]   = int'(cfg_div);
      m_high[cfg_ch]  = int'(cfg_high);
      m_phase[cfg_ch] = int'(cfg_phase);
      align_at = n;
    end
    e.rdy = (n != align_at);
    a = align_at + 1;
    lock_at = a + LOCK_CYCLES;
    e.lk = (n >= lock_at);
    for (int i = 0; i < N_CH; i++) begin
      r = pos(lock_at, a, m_phase[i], m_div[i]);
      first = (r == 0) ? lock_at : lock_at + m_div[i] - r;
      c = pos(n, a, m_phase[i], m_div[i]);
      e.oc[i] = (n >= first) && (c < m_high[i]);
      e.tk[i] = (n >= first) && (c == 0);
    end
    exp_q.push_back(e);
  endtask

  // model: advances one cycle per edge, restarts on reset
  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // monitor: compares DUT outputs against the prediction for the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked", 32'(locked), 32'(e.lk), e.cyc);
        check("cfg_ready", 32'(cfg_ready), 32'(e.rdy), e.cyc);
        check("cfg_err", 32'(cfg_err), 32'(e.err), e.cyc);
        check("outclk", 32'(outclk), 32'(e.oc), e.cyc);
        check("tick", 32'(tick), 32'(e.tk), e.cyc);
      end
    end
  end

  task automatic send(input int ch, input int d, input int h, input int p);
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_high  = DIV_W'(h);
    cfg_phase = DIV_W'(p);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge refclk);
  endtask

  initial begin
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(30);
    send(1, 5, 2, 0);
    wait_cycles(40);
    send(0, 4, 2, 0);
    wait_cycles(3);
    send(1, 4, 2, 1);
    wait_cycles(40);
    send(0, 4, 4, 0);
    wait_cycles(5);
    send(3, 4, 2, 0);
    wait_cycles(10);
    send(2, 1, 0, 0);
    wait_cycles(5);
    send(2, 6, 3, 5);
    wait_cycles(9);
    send(0, 3, 1, 2);
    wait_cycles(40);
    for (int k = 0; k < 25; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      wait_cycles(int'($urandom_range(1, 40)));
    end
    send(1, 5, 2, 0);
    wait_cycles(30);
    @(posedge refclk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_locked", 32'(locked), 32'd0, -1);
    check("rst_outclk", 32'(outclk), 32'd0, -1);
    check("rst_tick", 32'(tick), 32'd0, -1);
    check("rst_ready", 32'(cfg_ready), 32'd0, -1);
    check("rst_err", 32'(cfg_err), 32'd0, -1);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
